lsu_mem_ctrl: RTL and testbench
===============================

LSU_MEM_CTRL -- requirements
Module: lsu_mem_ctrl

Interface
REQ-001 Parameter: ADDR_W, 32, byte-address width of request and bus address.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: req_valid  input  1  core presents a memory request.
REQ-005 Port: req_ready  output  1  block accepts a request this cycle.
REQ-006 Port: req_we  input  1  1 = store, 0 = load.
REQ-007 Port: req_mask  input  4  load code: 0000 LB, 0001 LH, 1000 LW, 0010 LBU, 0100 LHU.
REQ-008 Port: req_func3  input  3  store code: 000 SB, 001 SH, 010 SW.
REQ-009 Port: req_addr  input  ADDR_W  byte address.
REQ-010 Port: req_wdata  input  32  store data, right-aligned.
REQ-011 Port: resp_valid  output  1  one-cycle response strobe.
REQ-012 Port: resp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-013 Port: resp_err  output  1  misaligned or illegal code, valid with resp_valid.
REQ-014 Port: bus_req  output  1  memory access request.
REQ-015 Port: bus_we  output  1  bus write.
REQ-016 Port: bus_addr  output  ADDR_W  word address, bits [1:0] = 00.
REQ-017 Port: bus_be  output  4  byte-lane enables.
REQ-018 Port: bus_wdata  output  32  lane-positioned store data.
REQ-019 Port: bus_ack  input  1  memory completes access; bus_rdata valid same cycle.
REQ-020 Port: bus_rdata  input  32  memory read word.

Function
REQ-021 FSM states IDLE, BUS, RESP; req_ready SHALL be 1 only in IDLE.
REQ-022 IDLE, req_valid=1: legal aligned request -> latch request, go BUS; illegal code or misaligned -> go RESP with err=1, no bus activity.
REQ-023 Misaligned: half access with addr[0]=1; word access with addr[1:0]!=00; unlisted req_mask/req_func3 codes are illegal.
REQ-024 BUS: bus_req=1, bus_we/addr/be/wdata registered and stable until bus_ack; on bus_ack capture bus_rdata, go RESP.
REQ-025 RESP: resp_valid=1 for exactly one cycle with resp_rdata/resp_err registered, then IDLE.
REQ-026 Latency: accept in cycle N, bus_req from N+1, earliest ack N+1, resp_valid N+2; each wait cycle adds one.
REQ-027 Store lanes: SB be=0001<<addr[1:0], byte replicated to all lanes; SH be=0011 (addr[1]=0) or 1100, half replicated; SW be=1111.
REQ-028 Load be equal to access size/position as in REQ-027; bus_wdata=0 for loads.
REQ-029 Load data: select lane by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW pass-through.
REQ-030 bus_ack outside BUS SHALL be ignored; req_valid outside IDLE SHALL be ignored (not accepted).

Reset
REQ-031 rst_n low SHALL immediately force IDLE and clear bus_req, bus_we, bus_addr, bus_be, bus_wdata, resp_valid, resp_rdata, resp_err to 0; req_ready=1 while rst_n low... and after release.
REQ-032 Reset during BUS SHALL abort the access; no response is produced for it.

Structure
REQ-033 Package lsu_pkg SHALL hold the state enum, the five load-mask codes and three store func3 codes.
REQ-034 Lane select and sign/zero extension SHALL be a combinational sub-module lsu_load_extract.

Verification
REQ-035 LB addr 0x103, bus_rdata 0x80FF_1234, ack at first BUS cycle -> be=1000, resp_rdata 0xFFFF_FF80, err=0, resp_valid two cycles after accept.
REQ-036 LHU addr 0x102, bus_rdata 0x8001_0000 -> be=1100, resp_rdata 0x0000_8001.
REQ-037 SB addr 0x201, wdata 0x0000_00AB, ack delayed 3 cycles -> bus_addr 0x200, be=0010, bus_wdata 0xABAB_ABAB held stable 4 cycles, resp_rdata 0.
REQ-038 LW addr 0x102 -> no bus_req, resp_valid with err=1 one cycle after accept; req_mask 0011 -> same.
REQ-039 rst_n pulsed low mid-BUS -> bus_req 0 immediately, no resp_valid, next request accepted normally.
REQ-040 Back-to-back SW then LW with req_valid held -> second accepted only after RESP, no dropped or duplicated response.

Source files
------------

// File: rtl/lsu_pkg.sv
// Purpose : shared types and codes for the load/store unit memory controller.
// Latency : n/a (types, constants and a pure lane-enable helper only).
// Backpr. : n/a.
// Contents: FSM state enum, access-size enum, load-mask and store-func3 codes,
//           lane_be() helper mapping access size + byte offset to lane enables.
package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  // Load codes arrive on req_mask.
  localparam logic [3:0] MASK_LB  = 4'b0000;
  localparam logic [3:0] MASK_LH  = 4'b0001;
  localparam logic [3:0] MASK_LW  = 4'b1000;
  localparam logic [3:0] MASK_LBU = 4'b0010;
  localparam logic [3:0] MASK_LHU = 4'b0100;

  // Store codes arrive on req_func3.
  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  // Byte-lane enables for an access of size sz at byte offset off.
  function automatic logic [3:0] lane_be(input size_e sz, input logic [1:0] off);
    case (sz)
      SZ_BYTE: return 4'b0001 << off;
      SZ_HALF: return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_extract.sv
// Purpose : picks the addressed byte/half out of a bus word and extends it.
// Latency : combinational, zero cycles.
// Backpr. : none, pure function of its inputs.
// Ports   : rdata_i (bus word), off_i (byte offset), mask_i (load code),
//           data_o (right-aligned, sign/zero-extended load result).
module lsu_load_extract
  import lsu_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  off_i,
  input  logic [3:0]  mask_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (off_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    // Half accesses are aligned, so only off_i[1] picks the lane pair.
    half_sel = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    case (mask_i)
      MASK_LB:  data_o = {{24{byte_sel[7]}}, byte_sel};
      MASK_LBU: data_o = {24'h0, byte_sel};
      MASK_LH:  data_o = {{16{half_sel[15]}}, half_sel};
      MASK_LHU: data_o = {16'h0, half_sel};
      default:  data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Purpose : single-outstanding load/store controller between core and a
//           word-wide acked memory bus (lane steering, extension, alignment check).
// Latency : accept N -> bus_req N+1 -> resp_valid N+2 at best, +1 per ack wait
//           cycle; illegal/misaligned requests respond at N+1 with no bus access.
// Backpr. : req_ready only in IDLE; memory stalls by withholding bus_ack.
// Ports   : req_* core request, resp_* one-cycle response strobe,
//           bus_* registered memory access held stable until bus_ack.
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [3:0]        req_mask,
  input  logic [2:0]        req_func3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_be,
  output logic [31:0]       bus_wdata,
  input  logic              bus_ack,
  input  logic [31:0]       bus_rdata
);

  state_e state_q, state_d;

  // ---------------------------------------------------------------- decode
  logic        dec_legal;
  size_e       dec_size;
  logic        dec_misal;
  logic [3:0]  dec_be;
  logic [31:0] dec_wdata;
  logic        req_ok;
  logic        accept;

  always_comb begin
    dec_legal = 1'b1;
    dec_size  = SZ_BYTE;
    if (req_we) begin
      case (req_func3)
        F3_SB:   dec_size = SZ_BYTE;
        F3_SH:   dec_size = SZ_HALF;
        F3_SW:   dec_size = SZ_WORD;
        default: dec_legal = 1'b0;
      endcase
    end else begin
      case (req_mask)
        MASK_LB, MASK_LBU: dec_size = SZ_BYTE;
        MASK_LH, MASK_LHU: dec_size = SZ_HALF;
        MASK_LW:           dec_size = SZ_WORD;
        default:           dec_legal = 1'b0;
      endcase
    end

    dec_misal = ((dec_size == SZ_HALF) && req_addr[0]) ||
                ((dec_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
    dec_be    = lane_be(dec_size, req_addr[1:0]);

    // Store data is replicated across lanes so any enabled lane carries it.
    dec_wdata = '0;
    if (req_we) begin
      case (dec_size)
        SZ_BYTE: dec_wdata = {4{req_wdata[7:0]}};
        SZ_HALF: dec_wdata = {2{req_wdata[15:0]}};
        default: dec_wdata = req_wdata;
      endcase
    end
  end

  assign req_ok = dec_legal && !dec_misal;
  assign accept = (state_q == ST_IDLE) && req_valid;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (req_valid) state_d = req_ok ? ST_BUS : ST_RESP;
      ST_BUS:  if (bus_ack)   state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Strobes are pure decodes of the state register, so reset clears them
  // immediately and an aborted bus access never reaches RESP.
  always_comb begin
    req_ready  = (state_q == ST_IDLE);
    bus_req    = (state_q == ST_BUS);
    resp_valid = (state_q == ST_RESP);
  end

  // ---------------------------------------------------------------- datapath
  logic              bus_we_q,    bus_we_d;
  logic [ADDR_W-1:0] bus_addr_q,  bus_addr_d;
  logic [3:0]        bus_be_q,    bus_be_d;
  logic [31:0]       bus_wdata_q, bus_wdata_d;
  logic [3:0]        ld_mask_q,   ld_mask_d;
  logic [1:0]        ld_off_q,    ld_off_d;
  logic [31:0]       resp_rdata_q, resp_rdata_d;
  logic              resp_err_q,   resp_err_d;
  logic [31:0]       ld_data;

  lsu_load_extract u_extract (
    .rdata_i (bus_rdata),
    .off_i   (ld_off_q),
    .mask_i  (ld_mask_q),
    .data_o  (ld_data)
  );

  always_comb begin
    bus_we_d     = bus_we_q;
    bus_addr_d   = bus_addr_q;
    bus_be_d     = bus_be_q;
    bus_wdata_d  = bus_wdata_q;
    ld_mask_d    = ld_mask_q;
    ld_off_d     = ld_off_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    if (accept) begin
      if (req_ok) begin
        bus_we_d    = req_we;
        bus_addr_d  = {req_addr[ADDR_W-1:2], 2'b00};
        bus_be_d    = dec_be;
        bus_wdata_d = dec_wdata;
        ld_mask_d   = req_mask;
        ld_off_d    = req_addr[1:0];
      end else begin
        resp_rdata_d = '0;
        resp_err_d   = 1'b1;
      end
    end else if ((state_q == ST_BUS) && bus_ack) begin
      resp_rdata_d = bus_we_q ? 32'h0 : ld_data;
      resp_err_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_we_q     <= 1'b0;
      bus_addr_q   <= '0;
      bus_be_q     <= '0;
      bus_wdata_q  <= '0;
      ld_mask_q    <= '0;
      ld_off_q     <= '0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      bus_we_q     <= bus_we_d;
      bus_addr_q   <= bus_addr_d;
      bus_be_q     <= bus_be_d;
      bus_wdata_q  <= bus_wdata_d;
      ld_mask_q    <= ld_mask_d;
      ld_off_q     <= ld_off_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign bus_we     = bus_we_q;
  assign bus_addr   = bus_addr_q;
  assign bus_be     = bus_be_q;
  assign bus_wdata  = bus_wdata_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Purpose : self-checking bench for lsu_mem_ctrl: directed cases plus random
//           transactions compared against a byte-arithmetic reference model.
// Latency : checks exact cycle of bus_req and resp_valid relative to accept.
// Backpr. : drives random ack delays and junk req_valid/bus_ack while busy.
module tb_lsu_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [3:0]  req_mask = '0;
  logic [2:0]  req_func3 = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = '0;

  int n_checks = 0;
  int n_errors = 0;

  // Busy-cycle request drive: 0 = random junk, 1 = hold the nxt_* request.
  int          busy_mode = 0;
  logic        nxt_we;
  logic [3:0]  nxt_mask;
  logic [2:0]  nxt_f3;
  logic [31:0] nxt_addr, nxt_wdata;

  always #5 clk = ~clk;

  lsu_mem_ctrl #(.ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_mask(req_mask), .req_func3(req_func3), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: access size in bytes, alignment by modulo, lanes by shifting a
  // run of ones, replication by byte modulo, extension by signed arithmetic.
  function automatic void model(input bit we, input logic [3:0] mask, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] rdata, output bit err,
                                output logic [3:0] be, output logic [31:0] bwd,
                                output logic [31:0] rd);
    int nb = 0;
    bit sgn = 0;
    int off;
    longint v, lim;
    if (we) begin
      if (f3 == 3'd0) nb = 1;
      else if (f3 == 3'd1) nb = 2;
      else if (f3 == 3'd2) nb = 4;
    end else begin
      if (mask == 4'b0000) begin nb = 1; sgn = 1; end
      else if (mask == 4'b0001) begin nb = 2; sgn = 1; end
      else if (mask == 4'b1000) nb = 4;
      else if (mask == 4'b0010) nb = 1;
      else if (mask == 4'b0100) nb = 2;
    end
    off = int'(addr % 4);
    be = '0; bwd = '0; rd = '0;
    if (nb == 0) err = 1;
    else err = ((addr % nb) != 0);
    if (err) return;
    be = 4'(((1 << nb) - 1) << off);
    if (we) begin
      for (int i = 0; i < 4; i++) bwd[8*i +: 8] = wdata[8*(i % nb) +: 8];
    end else begin
      lim = 64'sd1 << (8 * nb);
      v = (longint'({32'h0, rdata}) >> (8 * off)) % lim;
      if (sgn && v >= lim / 2) v = v - lim;
      rd = v[31:0];
    end
  endfunction

  task automatic busy_drive();
    if (busy_mode == 1) begin
      req_valid = 1'b1; req_we = nxt_we; req_mask = nxt_mask; req_func3 = nxt_f3;
      req_addr = nxt_addr; req_wdata = nxt_wdata;
    end else begin
      req_valid = 1'($urandom % 2); req_we = 1'($urandom % 2); req_mask = 4'($urandom);
      req_func3 = 3'($urandom); req_addr = $urandom; req_wdata = $urandom;
    end
  endtask

  // One transaction; returns at the negedge of its RESP cycle.
  task automatic do_txn(input bit we, input logic [3:0] mask, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rdata, input int dly);
    bit err;
    logic [3:0] be;
    logic [31:0] bwd, rd;
    model(we, mask, f3, addr, wdata, rdata, err, be, bwd, rd);
    @(negedge clk);
    check("idle_ready", req_ready, 1);
    check("idle_resp_valid", resp_valid, 0);
    check("idle_bus_req", bus_req, 0);
    bus_ack = 1'($urandom % 2);   // must be ignored while idle
    bus_rdata = $urandom;
    req_valid = 1'b1; req_we = we; req_mask = mask; req_func3 = f3;
    req_addr = addr; req_wdata = wdata;
    @(negedge clk);
    if (err) begin
      check("err_resp_valid", resp_valid, 1);
      check("err_flag", resp_err, 1);
      check("err_rdata", resp_rdata, 0);
      check("err_no_bus", bus_req, 0);
      check("err_ready", req_ready, 0);
      busy_drive();
      bus_ack = 1'($urandom % 2);
    end else begin
      for (int c = 0; c <= dly; c++) begin
        if (c > 0) @(negedge clk);
        check("bus_req", bus_req, 1);
        check("bus_we", bus_we, we);
        check("bus_addr", bus_addr, addr & 32'hFFFF_FFFC);
        check("bus_be", bus_be, be);
        check("bus_wdata", bus_wdata, bwd);
        check("bus_resp_valid", resp_valid, 0);
        check("bus_ready", req_ready, 0);
        busy_drive();
        bus_ack = (c == dly);
        bus_rdata = (c == dly) ? rdata : $urandom;
      end
      @(negedge clk);
      check("resp_valid", resp_valid, 1);
      check("resp_err", resp_err, 0);
      check("resp_rdata", resp_rdata, rd);
      check("resp_bus_req", bus_req, 0);
      check("resp_ready", req_ready, 0);
      busy_drive();
      bus_ack = 1'($urandom % 2);
      bus_rdata = $urandom;
    end
  endtask

  initial begin
    bit we;
    logic [3:0] mk;
    logic [2:0] f3;
    logic [31:0] ad;
    logic [3:0] legal_masks [5] = '{4'b0000, 4'b0001, 4'b1000, 4'b0010, 4'b0100};

    // Reset state, with a request offered during reset.
    req_valid = 1'b1;
    #3;
    check("rst_ready", req_ready, 1);
    check("rst_bus_req", bus_req, 0);
    check("rst_bus_we", bus_we, 0);
    check("rst_bus_addr", bus_addr, 0);
    check("rst_bus_be", bus_be, 0);
    check("rst_bus_wdata", bus_wdata, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_rdata", resp_rdata, 0);
    check("rst_resp_err", resp_err, 0);
    @(negedge clk);
    req_valid = 1'b0;
    rst_n = 1'b1;

    // Directed cases.
    do_txn(0, 4'b0000, 3'd0, 32'h0000_0103, 32'h0, 32'h80FF_1234, 0);   // LB
    do_txn(0, 4'b0100, 3'd0, 32'h0000_0102, 32'h0, 32'h8001_0000, 1);   // LHU
    do_txn(1, 4'b0000, 3'b000, 32'h0000_0201, 32'h0000_00AB, 32'h0, 3); // SB
    do_txn(1, 4'b0000, 3'b001, 32'h0000_0302, 32'h1234_BEEF, 32'h0, 0); // SH upper
    do_txn(0, 4'b1000, 3'd0, 32'h0000_0102, 32'h0, 32'h1111_1111, 0);   // LW misaligned
    do_txn(0, 4'b0011, 3'd0, 32'h0000_0100, 32'h0, 32'h1111_1111, 0);   // illegal mask
    do_txn(1, 4'b0000, 3'b011, 32'h0000_0100, 32'h5, 32'h0, 0);         // illegal func3
    do_txn(0, 4'b0001, 3'd0, 32'h0000_0101, 32'h0, 32'h0, 0);           // LH odd

    // SW then LW with req_valid held throughout.
    nxt_we = 0; nxt_mask = 4'b1000; nxt_f3 = 3'd0; nxt_addr = 32'h0000_0300; nxt_wdata = 32'h0;
    busy_mode = 1;
    do_txn(1, 4'b0000, 3'b010, 32'h0000_0040, 32'h1234_5678, 32'h0, 1);
    busy_mode = 0;
    do_txn(0, 4'b1000, 3'd0, 32'h0000_0300, 32'h0, 32'hCAFE_F00D, 0);

    // Reset pulsed while the bus access is pending.
    @(negedge clk);
    bus_ack = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_mask = 4'b1000; req_addr = 32'h0000_0400;
    @(negedge clk);
    req_valid = 1'b0;
    check("abort_bus_req_before", bus_req, 1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_bus_req", bus_req, 0);
    check("abort_bus_addr", bus_addr, 0);
    check("abort_bus_be", bus_be, 0);
    check("abort_resp_valid", resp_valid, 0);
    check("abort_ready", req_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    bus_ack = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("abort_no_resp", resp_valid, 0);
      check("abort_no_bus", bus_req, 0);
    end
    do_txn(0, 4'b0010, 3'd0, 32'h0000_0402, 32'h0, 32'h00F1_0000, 2);   // LBU

    // Random traffic.
    for (int n = 0; n < 300; n++) begin
      we = 1'($urandom % 2);
      mk = ($urandom % 8 == 0) ? 4'($urandom) : legal_masks[$urandom % 5];
      f3 = ($urandom % 8 == 0) ? 3'($urandom) : 3'($urandom % 3);
      ad = $urandom;
      if ($urandom % 2 == 1) ad[1:0] = 2'b00;
      do_txn(we, mk, f3, ad, $urandom, $urandom, int'($urandom_range(0, 3)));
    end

    @(negedge clk);
    req_valid = 1'b0;
    bus_ack = 1'b0;
    check("final_ready", req_ready, 1);
    check("final_resp_valid", resp_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
